// File: rtl/lc3_operate_sequencer.sv
// lc3_operate_sequencer: steers the LC-3 ALU through ADD/AND/NOT and writes results back with condition codes
module lc3_operate_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [15:0] alu_operand0,
  output logic [15:0] alu_operand2,
  output logic [4:0]  alu_operand1,
  output logic        alu_sr2mux,
  output logic [1:0]  alu_opcode,
  input  logic [15:0] alu_result,
  output logic        done,
  output logic        illegal,
  output logic [2:0]  dr,
  output logic [15:0] result,
  output logic [2:0]  nzp,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);
  typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, WRITEBACK} state_t;
  state_t      state;
  logic [15:0] ir;
  logic [15:0] hold;
  logic [15:0] regs [8];
  logic        bad;
  logic        is_add, is_and, is_not, legal;
  logic [15:0] sr1_val, sr2_val;
  assign is_add      = ir[15:12] == 4'b0001;
  assign is_and      = ir[15:12] == 4'b0101;
  assign is_not      = ir[15:12] == 4'b1001 && ir[5:0] == 6'b111111;
  assign legal       = is_add || is_and || is_not;
  assign sr1_val     = regs[ir[8:6]];
  assign sr2_val     = regs[ir[2:0]];
  assign instr_ready = state == IDLE && !rst;
  assign dbg_data    = regs[dbg_addr];
  // Sequencer FSM; a rejected instruction lingers one extra DECODE cycle (bad) so ready returns after T2
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ir           <= '0;
      hold         <= '0;
      bad          <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      alu_operand0 <= '0;
      alu_operand2 <= '0;
      alu_operand1 <= '0;
      alu_sr2mux   <= 1'b0;
      alu_opcode   <= 2'b00;
      done         <= 1'b0;
      illegal      <= 1'b0;
      dr           <= '0;
      result       <= '0;
      nzp          <= 3'b010;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: if (instr_valid) begin
          ir    <= instr;
          state <= DECODE;
        end
        DECODE: if (bad) begin
          bad   <= 1'b0;
          state <= IDLE;
        end else if (!legal) begin
          illegal <= 1'b1;
          bad     <= 1'b1;
        end else begin
          alu_opcode   <= is_not ? 2'b10 : is_and ? 2'b01 : 2'b00;
          alu_sr2mux   <= !is_not && ir[5];
          alu_operand0 <= is_not ? sr1_val : sr2_val;
          alu_operand2 <= sr1_val;
          alu_operand1 <= ir[4:0];
          state        <= EXECUTE;
        end
        EXECUTE: begin
          hold  <= alu_result;
          state <= WRITEBACK;
        end
        WRITEBACK: begin
          regs[ir[11:9]] <= hold;
          dr             <= ir[11:9];
          result         <= hold;
          nzp            <= hold[15] ? 3'b100 : hold == 16'h0000 ? 3'b010 : 3'b001;
          done           <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lc3_operate_sequencer.sv
// tb_lc3_operate_sequencer: directed and random operate instructions checked against an ISA-level model
module tb_lc3_operate_sequencer;
  logic        clk, rst, instr_valid, instr_ready, alu_sr2mux, done, illegal;
  logic [15:0] instr, alu_operand0, alu_operand2, alu_result, result, dbg_data;
  logic [4:0]  alu_operand1;
  logic [1:0]  alu_opcode;
  logic [2:0]  dr, nzp, dbg_addr;
  int checks = 0, failures = 0;
  logic [15:0] m_r [8];
  logic [2:0]  m_nzp, m_dr;
  logic [15:0] m_res;

  lc3_operate_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .alu_operand0(alu_operand0), .alu_operand2(alu_operand2), .alu_operand1(alu_operand1),
    .alu_sr2mux(alu_sr2mux), .alu_opcode(alu_opcode), .alu_result(alu_result),
    .done(done), .illegal(illegal), .dr(dr), .result(result), .nzp(nzp),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // LC-3 ALU: the MUX picks sign-extended imm5 or operand0; NOT inverts the MUX output
  logic [15:0] mux_out;
  always_comb begin
    mux_out    = alu_sr2mux ? {{11{alu_operand1[4]}}, alu_operand1} : alu_operand0;
    alu_result = alu_opcode == 2'b00 ? alu_operand2 + mux_out :
                 alu_opcode == 2'b01 ? alu_operand2 & mux_out :
                 alu_opcode == 2'b10 ? ~mux_out : alu_operand2;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] cc(input logic [15:0] v);
    return v[15] ? 3'b100 : v == 16'h0000 ? 3'b010 : 3'b001;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
    m_nzp = 3'b010;
    m_dr  = 3'd0;
    m_res = 16'h0000;
  endtask

  task automatic run(input logic [15:0] ins);
    logic [3:0]  op;
    logic        ok;
    logic [15:0] a, b, v;
    op = ins[15:12];
    ok = op == 4'd1 || op == 4'd5 || (op == 4'd9 && ins[5:0] == 6'h3f);
    a  = m_r[ins[8:6]];
    b  = ins[5] ? {{11{ins[4]}}, ins[4:0]} : m_r[ins[2:0]];
    v  = op == 4'd1 ? a + b : op == 4'd5 ? a & b : ~a;
    @(negedge clk);
    chk("ready_idle", 16'(instr_ready), 16'd1);
    instr_valid = 1;
    instr       = ins;
    dbg_addr    = ins[11:9];
    @(posedge clk); #1;
    instr_valid = 0;
    instr       = 16'($urandom);
    chk("ready_busy", 16'(instr_ready), 16'd0);
    @(posedge clk); #1;
    if (ok) begin
      chk("alu_opcode", 16'(alu_opcode), op == 4'd9 ? 16'd2 : op == 4'd5 ? 16'd1 : 16'd0);
      chk("alu_sr2mux", 16'(alu_sr2mux), op == 4'd9 ? 16'd0 : 16'(ins[5]));
      chk("alu_operand0", alu_operand0, op == 4'd9 ? a : m_r[ins[2:0]]);
      if (op != 4'd9) begin
        chk("alu_operand2", alu_operand2, a);
        chk("alu_operand1", 16'(alu_operand1), 16'(ins[4:0]));
      end
      chk("no_illegal", 16'(illegal), 16'd0);
      @(posedge clk); #1;
      chk("done_early", 16'(done), 16'd0);
      @(posedge clk); #1;
      m_r[ins[11:9]] = v;
      m_dr  = ins[11:9];
      m_res = v;
      m_nzp = cc(v);
      chk("done", 16'(done), 16'd1);
      chk("dr", 16'(dr), 16'(m_dr));
      chk("result", result, m_res);
      chk("nzp", 16'(nzp), 16'(m_nzp));
      chk("dbg_dr", dbg_data, m_r[ins[11:9]]);
      chk("ready_back", 16'(instr_ready), 16'd1);
    end else begin
      chk("illegal", 16'(illegal), 16'd1);
      chk("ill_no_done", 16'(done), 16'd0);
      chk("ill_ready_low", 16'(instr_ready), 16'd0);
      @(posedge clk); #1;
      chk("ill_pulse_end", 16'(illegal), 16'd0);
      chk("ill_ready_back", 16'(instr_ready), 16'd1);
      chk("ill_no_done2", 16'(done), 16'd0);
      chk("ill_nzp", 16'(nzp), 16'(m_nzp));
      chk("ill_reg", dbg_data, m_r[ins[11:9]]);
      chk("ill_dr", 16'(dr), 16'(m_dr));
      chk("ill_result", result, m_res);
    end
  endtask

  initial begin
    int hs [2];
    int n;
    logic [15:0] ins;
    rst = 1; instr_valid = 0; instr = 16'h0000; dbg_addr = 3'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 16'(instr_ready), 16'd0);
    rst = 0;
    #1;
    chk("rst_ready_after", 16'(instr_ready), 16'd1);
    chk("rst_nzp", 16'(nzp), 16'd2);
    chk("rst_dr", 16'(dr), 16'd0);
    chk("rst_result", result, 16'h0000);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_illegal", 16'(illegal), 16'd0);
    chk("rst_opcode", 16'(alu_opcode), 16'd0);
    chk("rst_sr2mux", 16'(alu_sr2mux), 16'd0);
    chk("rst_op0", alu_operand0, 16'h0000);
    chk("rst_op2", alu_operand2, 16'h0000);
    chk("rst_op1", 16'(alu_operand1), 16'd0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1 chk("rst_reg", dbg_data, 16'h0000);
    end
    run(16'h1225);
    run(16'h147A);
    run(16'h5681);
    run(16'h987F);
    run(16'h9840);
    run(16'h0E12);
    // back-to-back: valid held high across two ADDs
    @(negedge clk);
    instr_valid = 1;
    instr       = 16'h1DA1;
    dbg_addr    = 3'd6;
    n = 0;
    for (int c = 0; c < 12 && n < 2; c++) begin
      if (c > 0) @(negedge clk);
      if (instr_ready) begin
        hs[n] = c;
        n++;
      end
    end
    @(posedge clk); #1;
    instr_valid = 0;
    chk("b2b_count", 16'(n), 16'd2);
    if (n == 2) chk("b2b_spacing", 16'(hs[1] - hs[0]), 16'd4);
    repeat (3) @(posedge clk);
    #1;
    m_r[6] = m_r[6] + 16'd2;
    m_dr   = 3'd6;
    m_res  = m_r[6];
    m_nzp  = cc(m_r[6]);
    chk("b2b_done", 16'(done), 16'd1);
    chk("b2b_reg", dbg_data, m_r[6]);
    chk("b2b_nzp", 16'(nzp), 16'(m_nzp));
    // reset while ADD R5,R0,#1 is in EXECUTE
    @(negedge clk);
    instr_valid = 1;
    instr       = 16'h1A21;
    @(posedge clk); #1;
    instr_valid = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    chk("midrst_ready", 16'(instr_ready), 16'd0);
    chk("midrst_done", 16'(done), 16'd0);
    rst = 0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_done", 16'(done), 16'd0);
    end
    dbg_addr = 3'd5;
    #1;
    chk("midrst_r5", dbg_data, 16'h0000);
    chk("midrst_nzp", 16'(nzp), 16'd2);
    // random mix of legal and illegal instructions
    for (int k = 0; k < 150; k++) begin
      int r;
      r   = int'($urandom_range(0, 9));
      ins = 16'($urandom);
      if (r < 4) ins[15:12] = 4'b0001;
      else if (r < 7) ins[15:12] = 4'b0101;
      else if (r == 7) begin
        ins[15:12] = 4'b1001;
        ins[5:0]   = 6'h3f;
      end else if (r == 8) begin
        ins[15:12] = 4'b1001;
        if (ins[5:0] == 6'h3f) ins[5:0] = 6'h00;
      end else begin
        while (ins[15:12] == 4'd1 || ins[15:12] == 4'd5 || ins[15:12] == 4'd9)
          ins[15:12] = 4'($urandom);
      end
      run(ins);
    end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1 chk("final_reg", dbg_data, m_r[i]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lc3_operate_sequencer.md
# lc3_operate_sequencer

Control and datapath sequencer that drives the LC-3 ALU for operate-class instructions (ADD, AND, NOT). It accepts one 16-bit instruction per valid/ready handshake and reads source operands from an internal 8×16 register file. It steers the ALU's operand, SR2MUX, imm5 and opcode inputs, captures the ALU result, writes it back to DR and updates the NZP condition codes. It sits between instruction fetch and the ALU, and supplies every control input the ALU consumes.

## Interface
- No parameters. Widths are fixed by the LC-3 ISA.
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr  in  16  LC-3 instruction word
- instr_ready  out  1  sequencer can accept an instruction
- alu_operand0  out  16  SR2 value (register-mode second source; also the NOT source)
- alu_operand2  out  16  SR1 value
- alu_operand1  out  5  imm5 field, instr[4:0]
- alu_sr2mux  out  1  instr[5] for ADD/AND; 0 for NOT
- alu_opcode  out  2  00 ADD, 01 AND, 10 NOT, 11 PASS1
- alu_result  in  16  combinational ALU output
- done  out  1  one-cycle pulse at writeback
- illegal  out  1  one-cycle pulse on a rejected instruction
- dr  out  3  destination register of the last completed instruction
- result  out  16  value written at the last writeback
- nzp  out  3  condition codes {N,Z,P}
- dbg_addr  in  3  debug register-file read address
- dbg_data  out  16  combinational read of regfile[dbg_addr]

## Operation
- State machine with four states: IDLE, DECODE, EXECUTE, WRITEBACK.
- IDLE: instr_ready = 1. On instr_valid && instr_ready, latch instr into IR and go to DECODE. instr_ready = 0 in every other state.
- DECODE:
  - instr[15:12] = 0001 selects ADD; 0101 selects AND.
  - 1001 selects NOT, which is legal only when instr[5:0] = 111111.
  - Any other opcode, or a NOT with a bad low field, is illegal: pulse illegal in the next cycle, return to IDLE, and leave regfile, nzp, dr and result unchanged.
  - Legal instruction: register the ALU controls, then go to EXECUTE.
- ALU steering:
  - ADD/AND: alu_operand2 = R[instr[8:6]]; alu_operand0 = R[instr[2:0]]; alu_sr2mux = instr[5]; alu_operand1 = instr[4:0].
  - NOT: alu_operand0 = R[instr[8:6]] and alu_sr2mux = 0. The ALU's NOT inverts its MUX output, so the source must go on the SR2 path.
- EXECUTE: capture alu_result into a holding register; go to WRITEBACK.
- WRITEBACK:
  - R[instr[11:9]] <= held value; dr and result updated.
  - nzp = 100 if bit15 is set, 010 if the value is zero, 001 otherwise. Exactly one bit is ever set.
  - Pulse done; go to IDLE.
- DR may equal SR1 or SR2. Sources are read in DECODE, before the write, so the instruction uses the old value.
- ALU outputs hold their last driven value outside DECODE/EXECUTE.

## Timing
- Handshake accepted at edge T0. ALU controls are valid from T1. Result is captured at T2. done, regfile write and nzp are visible after T3. instr_ready returns to 1 after T3.
- Legal instruction: 3-cycle latency, one instruction per 4 cycles.
- Illegal instruction: pulse visible in the cycle after T1; instr_ready = 1 again after T2.
- instr is sampled only at the handshake edge; later changes are ignored.
- Reset values:
  - State IDLE; all registers 0x0000.
  - nzp = 010; dr = 0, result = 0x0000; done = 0, illegal = 0.
  - alu_opcode = 00, alu_sr2mux = 0; ALU operands are all 0.
- While rst is high, instr_ready = 0.
- Reset mid-operation at any state: the in-flight instruction is discarded. No done pulse, no register or nzp write.

## Test plan
- Reset, then ADD R1,R0,#5 (0x1225) -> alu_opcode=00 and sr2mux=1 at T1; done at T3; dr=1, result=0x0005, nzp=001.
- ADD R2,R1,#-6 (0x147A) -> result=0xFFFF, nzp=100; dbg_addr=2 reads 0xFFFF.
- AND R3,R2,R1 register mode (0x5681) -> alu_operand0=0x0005, alu_operand2=0xFFFF, sr2mux=0; result=0x0005, nzp=001.
- NOT R4,R1 (0x987F) -> alu_opcode=10, alu_operand0=0x0005; result=0xFFFA, nzp=100.
- Illegal cases:
  - NOT with low field 000000 (0x9840) -> illegal pulse one cycle after T1; no done; R4 and nzp unchanged.
  - Opcode 0000 -> same response.
- instr_valid held high with two ADDs queued -> second handshake exactly 4 cycles after the first.
- rst asserted during EXECUTE of ADD R5,R0,#1 -> no done; R5 reads 0; nzp=010.
